uart_rx_loader: RTL
===================

Name: uart_rx_loader

Overview:
Controller that sequences the byte stream from the UART receiver.
- Boot phase: collects a 32-bit word count N, then N little-endian 32-bit words, and writes them to instruction memory at consecutive addresses.
- Run phase: assembles later bytes into 32-bit words and buffers them in a first-word-fall-through FIFO for the core's input port.
- Sits between the UART receiver (rdata/rdata_ready/ferr) and both imem and the core.

Parameters:
ADDR_W, 15, imem word-address width.
DEPTH_LOG2, 4, log2 of run-phase FIFO depth in 32-bit words (depth 16).

Ports:
clk  in  1  system clock, all state on rising edge.
rstn  in  1  reset.
rx_data  in  8  received byte.
rx_valid  in  1  one-cycle pulse: rx_data valid.
rx_ferr  in  1  receiver framing-error flag, sampled with rx_valid.
boot_start  in  1  pulse: begin boot load; ignored outside IDLE.
imem_we  out  1  imem write strobe, one cycle per word.
imem_addr  out  ADDR_W  imem word address.
imem_wdata  out  32  imem write data.
boot_done  out  1  sticky: boot load complete.
word_valid  out  1  FIFO non-empty.
word_data  out  32  FIFO head word.
word_ready  in  1  core pops head when word_valid && word_ready.
err  out  1  sticky: framing error (or checksum mismatch).
ovf  out  1  sticky: run-phase word dropped, FIFO full.

Behaviour:
Interface (already decided):
- One clock, clk.
- Reset rstn is asynchronous, active-low.

Reset:
- All outputs 0, state IDLE, byte counter 0, word index 0, FIFO empty.
- Reset asserted mid-operation aborts immediately; partial words are discarded.

Byte assembly:
- 2-bit byte counter. Byte k of a word goes to bits [8k+7:8k] (little-endian).
- The counter clears after the 4th byte.
- On the edge sampling the 4th rx_valid, the complete word {rx_data, partial[23:0]} is consumed by the current state.

State machine:
- IDLE:
  - rx_valid bytes are dropped; the counter stays 0.
  - boot_start -> LEN.
- LEN:
  - The 4th byte completes N.
  - If N==0: -> RUN, and boot_done=1 from the next cycle.
  - Otherwise: -> LOAD with index=0.
- LOAD:
  - Each completed word drives imem_we=1, imem_addr=index[ADDR_W-1:0] and imem_wdata=word for exactly the cycle after the 4th byte's edge. index then increments.
  - imem_addr wraps modulo 2^ADDR_W; no error is flagged.
  - After word N-1 is written: -> RUN (or CSUM if enabled). boot_done sets in the same cycle as the final imem_we and stays set until reset.
- RUN:
  - Each completed word is pushed into the FIFO. word_valid rises the cycle after the 4th byte's edge.
  - No other states are reached until reset.
- boot_start is ignored outside IDLE.

FIFO:
- Depth 2^DEPTH_LOG2.
- word_data is combinational from the head entry.
- Push is accepted if not full, or if full with a pop in the same cycle.
- Otherwise the word is dropped and ovf is set (sticky).
- A simultaneous push and pop at empty is impossible (word_valid=0), so no bypass is needed.
- Pointers are DEPTH_LOG2+1 bits wide to distinguish full from empty.

Error handling:
- rx_valid && rx_ferr sets err (sticky).
- The byte is still used; sequencing is unaffected.

imem_we is never asserted outside LOAD/CSUM.

Optional Feature:
Macro: UART_LOADER_CHECKSUM_EN.
- Defined:
  - LOAD keeps a 32-bit wrapping sum of all loaded words.
  - After the last word, the state goes to CSUM and receives 4 more bytes (little-endian).
  - boot_done sets only when CSUM completes, then -> RUN.
  - A mismatch with the sum sets err; RUN is still entered.
  - With N==0 the expected sum is 0 and the CSUM phase still occurs.
- Undefined: no sum register and no CSUM state; LOAD -> RUN directly, as above.

Test Plan:
1. Reset, then boot_start, then bytes 02 00 00 00 78 56 34 12 EF BE AD DE. Required response:
   - imem writes addr0=0x12345678 and addr1=0xDEADBEEF, each imem_we exactly 1 cycle.
   - boot_done=1 after the second write.
   - With the macro defined, boot_done instead requires bytes 67 15 E2 F0 afterwards; err must stay 0.
2. Same sequence with checksum bytes 00 00 00 00 (macro defined) -> boot_done=1, err=1, state RUN.
3. In RUN with word_ready=0, send 17 words (0x00000001..0x00000011):
   - First 16 words buffered; ovf=1 on the 17th.
   - Raising word_ready pops 0x1..0x10 in order, one per cycle; then word_valid=0.
4. FIFO full with word_ready=1 held while a 17th word completes -> no ovf; the word is buffered behind the remaining entries.
5. Bytes sent before boot_start are dropped. boot_start, then 00 00 00 00:
   - Macro undefined: boot_done=1 with no imem_we.
   - Macro defined: boot_done=1 only after a further 00 00 00 00.
6. Pulse rstn low after 2 of 4 bytes of a LOAD word -> all outputs 0 immediately. boot_start with a fresh stream restarts at addr0. A byte with rx_ferr=1 -> err=1, data still written.

Source files
------------

// File: rtl/uart_rx_loader.sv
// UART byte-stream loader: boot phase writes a length-prefixed word image to imem,
// run phase buffers assembled words in a FWFT FIFO. Optional: UART_LOADER_CHECKSUM_EN.
module uart_rx_loader #(
  parameter int ADDR_W     = 15,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_ferr,
  input  logic              boot_start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              boot_done,
  output logic              word_valid,
  output logic [31:0]       word_data,
  input  logic              word_ready,
  output logic              err,
  output logic              ovf
);

`ifdef UART_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_LOAD, S_CSUM, S_RUN} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_LOAD, S_RUN} state_t;
`endif

  localparam int DEPTH = 1 << DEPTH_LOG2;

  state_t              r_state;
  logic [1:0]          r_bcnt;
  logic [23:0]         r_part;
  logic [31:0]         r_len;
  logic [31:0]         r_idx;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [31:0]         r_sum;
`endif
  logic                r_imem_we;
  logic [ADDR_W-1:0]   r_imem_addr;
  logic [31:0]         r_imem_wdata;
  logic                r_boot_done;
  logic                r_err;
  logic                r_ovf;

  logic [31:0]         r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wptr;
  logic [DEPTH_LOG2:0] r_rptr;

  logic [31:0]         w_word;
  logic                w_word_done;
  logic                w_run_push;
  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_push;

  assign w_word      = {rx_data, r_part};
  assign w_word_done = rx_valid && (r_state != S_IDLE) && (r_bcnt == 2'd3);
  assign w_run_push  = w_word_done && (r_state == S_RUN);
  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (r_wptr[DEPTH_LOG2] != r_rptr[DEPTH_LOG2]) &&
                       (r_wptr[DEPTH_LOG2-1:0] == r_rptr[DEPTH_LOG2-1:0]);
  assign w_pop       = !w_empty && word_ready;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign w_push      = w_run_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_bcnt       <= '0;
      r_part       <= '0;
      r_len        <= '0;
      r_idx        <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
      r_sum        <= '0;
`endif
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_boot_done  <= 1'b0;
      r_err        <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_imem_we <= 1'b0;
      if (rx_valid && rx_ferr) r_err <= 1'b1;
      if (w_run_push && !w_push) r_ovf <= 1'b1;

      if (rx_valid && (r_state != S_IDLE)) begin
        r_bcnt <= r_bcnt + 2'd1;
        case (r_bcnt)
          2'd0:    r_part[7:0]   <= rx_data;
          2'd1:    r_part[15:8]  <= rx_data;
          2'd2:    r_part[23:16] <= rx_data;
          default: ;
        endcase
      end

      case (r_state)
        S_IDLE: begin
          if (boot_start) begin
            r_state <= S_LEN;
            r_idx   <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
            r_sum   <= '0;
`endif
          end
        end
        S_LEN: begin
          if (w_word_done) begin
            r_len <= w_word;
            r_idx <= '0;
            if (w_word == '0) begin
`ifdef UART_LOADER_CHECKSUM_EN
              r_state     <= S_CSUM;
`else
              r_state     <= S_RUN;
              r_boot_done <= 1'b1;
`endif
            end else begin
              r_state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (w_word_done) begin
            r_imem_we    <= 1'b1;
            r_imem_addr  <= r_idx[ADDR_W-1:0];
            r_imem_wdata <= w_word;
            r_idx        <= r_idx + 32'd1;
`ifdef UART_LOADER_CHECKSUM_EN
            r_sum        <= r_sum + w_word;
`endif
            if (r_idx == r_len - 32'd1) begin
`ifdef UART_LOADER_CHECKSUM_EN
              r_state     <= S_CSUM;
`else
              r_state     <= S_RUN;
              r_boot_done <= 1'b1;
`endif
            end
          end
        end
`ifdef UART_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (w_word_done) begin
            if (w_word != r_sum) r_err <= 1'b1;
            r_boot_done <= 1'b1;
            r_state     <= S_RUN;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage is not reset; word_data is gated by word_valid instead.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[DEPTH_LOG2-1:0]] <= w_word;
  end

  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign boot_done  = r_boot_done;
  assign err        = r_err;
  assign ovf        = r_ovf;
  assign word_valid = !w_empty;
  assign word_data  = w_empty ? '0 : r_mem[r_rptr[DEPTH_LOG2-1:0]];

endmodule
